// File: rtl/bg_pixel_prefetch.sv
// Background picture pixel prefetcher.
// Streams one frame of 16-bit background pixels from SDRAM into a small FIFO
// and presents one pixel per active-display ce_pix as b/a/r/g nibbles.
// Reads are restarted at BASE_ADDR on every vs rising edge; a read still in
// flight across that edge is completed and its data discarded.
module bg_pixel_prefetch #(
  parameter int unsigned        FIFO_DEPTH = 16,
  parameter int unsigned        ADDR_W     = 25,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter int unsigned        FRAME_PIX  = 307200
) (
  input  logic              clk_50,
  input  logic              reset_l,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vs,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_dout,
  input  logic              mem_ready,
  output logic [3:0]        bg_r,
  output logic [3:0]        bg_g,
  output logic [3:0]        bg_b,
  output logic [3:0]        bg_a,
  output logic              underrun
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FCNT_W = $clog2(FRAME_PIX + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [FCNT_W-1:0] FRAME_C = FCNT_W'(FRAME_PIX);

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DROP
  } fetch_state_t;

  // Frame-start detection
  logic                r_vs_q;
  logic                w_start;

  // Fetch FSM
  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic                w_issue;
  logic                w_push;

  // Read request / address tracking
  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [FCNT_W-1:0]   r_fetch_cnt;

  // Pixel FIFO
  logic [15:0]         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_fifo_empty;
  logic [15:0]         w_fifo_rdata;
  logic                w_pop;

  // Pixel output
  logic                w_active;
  logic [15:0]         r_pix;
  logic                r_underrun;

  assign w_start      = vs & ~r_vs_q;
  assign w_active     = ~(hblank | vblank);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_rdata = r_fifo[r_rd_ptr];
  assign w_pop        = ce_pix & enable & w_active & ~w_fifo_empty;

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign bg_b     = r_pix[15:12];
  assign bg_a     = r_pix[11:8];
  assign bg_r     = r_pix[7:4];
  assign bg_g     = r_pix[3:0];
  assign underrun = r_underrun;

  // Delayed copy of vs for rising-edge detection
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      r_vs_q <= 1'b0;
    end else begin
      r_vs_q <= vs;
    end
  end

  // Fetch FSM state register
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= F_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch FSM next state; frame start overrides normal sequencing and sends
  // any still-pending read to F_DROP unless it completes this very cycle
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      if ((r_state != F_IDLE) && !mem_ready) begin
        w_state_nxt = F_DROP;
      end else begin
        w_state_nxt = F_IDLE;
      end
    end else begin
      unique case (r_state)
        F_IDLE: if (w_issue)   w_state_nxt = F_WAIT;
        F_WAIT: if (mem_ready) w_state_nxt = F_IDLE;
        F_DROP: if (mem_ready) w_state_nxt = F_IDLE;
        default:               w_state_nxt = F_IDLE;
      endcase
    end
  end

  // Fetch FSM outputs: issue a read when there is room and the frame is not
  // fully fetched; accept returned data only for a read of this frame
  always_comb begin
    w_issue = 1'b0;
    w_push  = 1'b0;
    unique case (r_state)
      F_IDLE: w_issue = enable & (r_count < DEPTH_C) &
                        (r_fetch_cnt < FRAME_C) & ~w_start;
      F_WAIT: w_push  = mem_ready & ~w_start;
      F_DROP: w_push  = 1'b0;
      default: begin
        w_issue = 1'b0;
        w_push  = 1'b0;
      end
    endcase
  end

  // Registered read request pulse and its address
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      r_mem_rd   <= 1'b0;
      r_mem_addr <= BASE_ADDR;
    end else begin
      r_mem_rd <= w_issue;
      if (w_issue) begin
        r_mem_addr <= r_next_addr;
      end
    end
  end

  // Next fetch address and per-frame fetch count advance on each accepted word
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      r_next_addr <= BASE_ADDR;
      r_fetch_cnt <= '0;
    end else if (w_start) begin
      r_next_addr <= BASE_ADDR;
      r_fetch_cnt <= '0;
    end else if (w_push) begin
      r_next_addr <= r_next_addr + ADDR_W'(2);
      r_fetch_cnt <= r_fetch_cnt + FCNT_W'(1);
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk_50) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= mem_dout;
    end
  end

  // FIFO pointers and occupancy; frame start flushes everything
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Pixel output on ce_pix: popped word when active, transparent on empty
  // (flagging underrun), hold during blanking; underrun clears at frame start
  always_ff @(posedge clk_50 or negedge reset_l) begin
    if (!reset_l) begin
      r_pix      <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (ce_pix) begin
        if (!enable) begin
          r_pix <= '0;
        end else if (w_active) begin
          if (w_fifo_empty) begin
            r_pix      <= '0;
            r_underrun <= 1'b1;
          end else begin
            r_pix <= w_fifo_rdata;
          end
        end
      end
      if (w_start) begin
        r_underrun <= 1'b0;
      end
    end
  end

endmodule
